// File: rtl/in_port_bank_if.sv
// Bus/handshake bundle for in_port_bank: channel push side plus CPU read/pop/status side.
// IN_PORT_IRQ_EN adds the irq mask load strobe and the bus word it loads from.
interface in_port_bank_if #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*DATA_W-1:0] ext_data;
  logic [NUM_CH-1:0]        ext_strobe;
  logic [NUM_CH-1:0]        ext_ready;
  logic [CH_W-1:0]          ch_sel;
  logic                     in_port_out;
  logic                     in_port_pop;
  logic                     stat_out;
  logic                     stat_clr;
  logic [DATA_W-1:0]        bus_data_out;
  logic                     irq;
`ifdef IN_PORT_IRQ_EN
  logic                     irq_mask_ld;
  logic [DATA_W-1:0]        bus_data_in;
`endif

  modport slave (
`ifdef IN_PORT_IRQ_EN
    input  irq_mask_ld,
    input  bus_data_in,
`endif
    input  ext_data,
    input  ext_strobe,
    output ext_ready,
    input  ch_sel,
    input  in_port_out,
    input  in_port_pop,
    input  stat_out,
    input  stat_clr,
    output bus_data_out,
    output irq
  );

  modport master (
`ifdef IN_PORT_IRQ_EN
    output irq_mask_ld,
    output bus_data_in,
`endif
    output ext_data,
    output ext_strobe,
    input  ext_ready,
    output ch_sel,
    output in_port_out,
    output in_port_pop,
    output stat_out,
    output stat_clr,
    input  bus_data_out,
    input  irq
  );
endinterface

// File: rtl/in_port_bank.sv
// Multi-channel buffered input port: per-channel FIFOs, first-word fall-through bus read, sticky flags.
// Optional interrupt with per-channel mask when IN_PORT_IRQ_EN is defined; otherwise irq is tied 0.
module in_port_bank #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int DEPTH  = 4
) (
  input logic            Clock,
  input logic            clr,
  in_port_bank_if.slave  bus
);
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [CNT_W-1:0]  cnt    [NUM_CH];
  logic [NUM_CH-1:0] ovf, udf;
  logic [NUM_CH-1:0] non_empty, full, push, pop_hit, pop_ok;
  logic              sel_valid;
  logic [DATA_W-1:0] head, stat_word;

  assign sel_valid = (int'(bus.ch_sel) < NUM_CH);

  always_comb begin
    non_empty = '0;
    full      = '0;
    push      = '0;
    pop_hit   = '0;
    pop_ok    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      non_empty[c] = (cnt[c] != '0);
      full[c]      = (cnt[c] == CNT_W'(DEPTH));
      // ready comes from the registered count only, so a same-edge pop never frees a slot
      push[c]      = bus.ext_strobe[c] && !full[c];
      pop_hit[c]   = bus.in_port_pop && sel_valid && (bus.ch_sel == CH_W'(c));
      pop_ok[c]    = pop_hit[c] && non_empty[c];
    end
  end

  assign bus.ext_ready = ~full;

  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      for (int c = 0; c < NUM_CH; c++) begin
        rd_ptr[c] <= '0;
        wr_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      ovf <= '0;
      udf <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (push[c])
          wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
        if (pop_ok[c])
          rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
        case ({push[c], pop_ok[c]})
          2'b10:   cnt[c] <= cnt[c] + CNT_W'(1);
          2'b01:   cnt[c] <= cnt[c] - CNT_W'(1);
          default: cnt[c] <= cnt[c];
        endcase
        // a flag-setting event outranks a same-cycle clear
        if (bus.ext_strobe[c] && full[c])
          ovf[c] <= 1'b1;
        else if (bus.stat_clr)
          ovf[c] <= 1'b0;
        if (pop_hit[c] && !non_empty[c])
          udf[c] <= 1'b1;
        else if (bus.stat_clr)
          udf[c] <= 1'b0;
      end
    end
  end

  // Storage needs no reset: the pointers and counts define which entries are valid.
  always_ff @(posedge Clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c])
        mem[c][wr_ptr[c]] <= bus.ext_data[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    head      = '0;
    stat_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel_valid && (bus.ch_sel == CH_W'(c)) && non_empty[c])
        head = mem[c][rd_ptr[c]];
      stat_word[c]            = non_empty[c];
      stat_word[NUM_CH + c]   = ovf[c];
      stat_word[2*NUM_CH + c] = udf[c];
    end
  end

  assign bus.bus_data_out = bus.stat_out    ? stat_word :
                            bus.in_port_out ? head      : '0;

`ifdef IN_PORT_IRQ_EN
  logic [NUM_CH-1:0] irq_mask;
  logic              irq_q;

  always_ff @(posedge Clock or negedge clr) begin
    if (!clr) begin
      irq_mask <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (bus.irq_mask_ld)
        irq_mask <= bus.bus_data_in[NUM_CH-1:0];
      irq_q <= (|(non_empty & irq_mask)) | (|ovf);
    end
  end

  assign bus.irq = irq_q;
`else
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_in_port_bank.sv
// Randomized bench for in_port_bank: queue-based reference model plus directed boundary scenarios.
module tb_in_port_bank;
  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 4;

  logic Clock = 1'b0;
  logic clr;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mq [NUM_CH][$];
  logic [NUM_CH-1:0] m_ovf, m_udf;
  logic [31:0] ob;
  logic [3:0]  orr;
  logic [127:0] d;

  always #5 Clock = ~Clock;

  in_port_bank_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) bus_if ();

  in_port_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .Clock (Clock),
    .clr   (clr),
    .bus   (bus_if.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      s[c]            = (mq[c].size() != 0);
      s[NUM_CH + c]   = m_ovf[c];
      s[2*NUM_CH + c] = m_udf[c];
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) mq[c].delete();
    m_ovf = '0;
    m_udf = '0;
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, then advance the model at the edge.
  task automatic step(input logic [3:0] stb, input logic [127:0] dat, input logic [1:0] sel,
                      input logic rd, input logic pp, input logic st, input logic sc,
                      output logic [31:0] obs_bus, output logic [3:0] obs_rdy);
    logic [31:0] e_bus;
    logic [3:0]  e_rdy;
    logic [31:0] hd;
    @(negedge Clock);
    bus_if.ext_strobe  = stb;
    bus_if.ext_data    = dat;
    bus_if.ch_sel      = sel;
    bus_if.in_port_out = rd;
    bus_if.in_port_pop = pp;
    bus_if.stat_out    = st;
    bus_if.stat_clr    = sc;
    #1;
    obs_bus = bus_if.bus_data_out;
    obs_rdy = bus_if.ext_ready;
    for (int c = 0; c < NUM_CH; c++) e_rdy[c] = (mq[c].size() < DEPTH);
    hd    = (mq[sel].size() != 0) ? mq[sel][0] : 32'h0;
    e_bus = st ? exp_status() : (rd ? hd : 32'h0);
    check("ready", {28'h0, obs_rdy}, {28'h0, e_rdy});
    check("bus", obs_bus, e_bus);
    @(posedge Clock);
    for (int c = 0; c < NUM_CH; c++) begin
      int sz;
      logic hit;
      sz  = mq[c].size();
      hit = pp && (int'(sel) == c);
      m_ovf[c] = (stb[c] && sz == DEPTH) || (m_ovf[c] && !sc);
      m_udf[c] = (hit && sz == 0) || (m_udf[c] && !sc);
      if (hit && sz > 0) void'(mq[c].pop_front());
      if (stb[c] && sz < DEPTH) mq[c].push_back(dat[c*32 +: 32]);
    end
  endtask

  task automatic do_reset(input logic [3:0] noise);
    @(negedge Clock);
    clr                = 1'b0;
    bus_if.ext_strobe  = noise;
    bus_if.ext_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
    bus_if.stat_out    = 1'b1;
    bus_if.in_port_out = 1'b0;
    bus_if.in_port_pop = 1'b0;
    bus_if.stat_clr    = 1'b0;
    #1;
    check("rst_ready", {28'h0, bus_if.ext_ready}, 32'hF);
    check("rst_status", bus_if.bus_data_out, 32'h0);
    @(negedge Clock);
    bus_if.stat_out    = 1'b0;
    bus_if.in_port_out = 1'b1;
    bus_if.ch_sel      = 2'($urandom_range(0, 3));
    #1;
    check("rst_data", bus_if.bus_data_out, 32'h0);
    check("rst_irq", {31'h0, bus_if.irq}, 32'h0);
    @(negedge Clock);
    bus_if.ext_strobe  = '0;
    bus_if.in_port_out = 1'b0;
    clr                = 1'b1;
    model_clear();
  endtask

  initial begin
    clr                = 1'b0;
    bus_if.ext_data    = '0;
    bus_if.ext_strobe  = '0;
    bus_if.ch_sel      = '0;
    bus_if.in_port_out = 1'b0;
    bus_if.in_port_pop = 1'b0;
    bus_if.stat_out    = 1'b0;
    bus_if.stat_clr    = 1'b0;
`ifdef IN_PORT_IRQ_EN
    bus_if.irq_mask_ld = 1'b0;
    bus_if.bus_data_in = '0;
`endif
    model_clear();
    do_reset(4'h0);

    // single word through channel 1
    d = '0; d[63:32] = 32'hDEADBEEF;
    step(4'b0010, d, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, ob, orr);
    step(4'b0000, '0, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, ob, orr);
    check("t2_head", ob, 32'hDEADBEEF);
    step(4'b0000, '0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, ob, orr);
    check("t2_nonempty1", {31'h0, ob[1]}, 32'h0);

    // overfill channel 0
    for (int i = 0; i < 5; i++) begin
      d = '0; d[31:0] = 32'h10 + 32'(i);
      step(4'b0001, d, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, ob, orr);
      if (i == 4) check("t3_ready_full", {31'h0, orr[0]}, 32'h0);
    end
    step(4'b0000, '0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, ob, orr);
    check("t3_ovf0", {31'h0, ob[4]}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(4'b0000, '0, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, ob, orr);
      check("t3_order", ob, 32'h10 + 32'(i));
    end

    // underflow on channel 2 with a same-cycle clear
    step(4'b0000, '0, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, ob, orr);
    check("t4_empty_read", ob, 32'h0);
    step(4'b0000, '0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, ob, orr);
    check("t4_udf_kept", {31'h0, ob[10]}, 32'h1);
    step(4'b0000, '0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, ob, orr);
    check("t4_udf_cleared", {31'h0, ob[10]}, 32'h0);

    // push and pop together on channel 3
    d = '0; d[127:96] = 32'h1;
    step(4'b1000, d, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ob, orr);
    d[127:96] = 32'h2;
    step(4'b1000, d, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, ob, orr);
    d[127:96] = 32'hA5;
    step(4'b1000, d, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, ob, orr);
    check("t5_first", ob, 32'h1);
    step(4'b0000, '0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, ob, orr);
    check("t5_second", ob, 32'h2);
    step(4'b0000, '0, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, ob, orr);
    check("t5_a5", ob, 32'hA5);
    step(4'b0000, '0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, ob, orr);
    check("t5_empty", {31'h0, ob[3]}, 32'h0);

    // reset mid-stream with all channels loaded
    for (int i = 0; i < 3; i++)
      step(4'hF, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, ob, orr);
    do_reset(4'hF);
    step(4'b0000, '0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, ob, orr);
    check("rst_mid_status", ob, 32'h0);

    // random traffic: fill-heavy phase, then drain-heavy phase
    for (int i = 0; i < 1600; i++) begin
      logic [3:0] stb;
      stb = (i < 800) ? 4'($urandom()) : (4'($urandom()) & 4'($urandom()));
      if (i == 1200) do_reset(4'($urandom()));
      step(stb, {$urandom(), $urandom(), $urandom(), $urandom()},
           2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) != 0),
           (i < 800) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 15) == 0),
           ob, orr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
